yuv2rgb_stream: RTL and testbench

- Parametrised, fully pipelined YUV 4:4:4 to RGB colour-space converter with valid/ready streaming on both sides.
- Next-generation replacement for the single-shot start/pixel_ready converter: one pixel per clock of throughput, configurable sample width, and run-time selectable BT.601/BT.709 matrix.
- Sits between the YUV pixel source (decoder/DMA reader) and the RGB display/frame-buffer writer.
- Saturating output; the per-pixel mode and frame markers travel with the data.

---
 rtl/yuv2rgb_stream.sv | 150 +++++++++++++++
 tb/tb_yuv2rgb_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/yuv2rgb_stream.sv
// Streaming YUV 4:4:4 -> RGB converter, BT.601/BT.709 per pixel, saturating output.
// Latency 3 clocks; a stalled output freezes the whole pipeline and drops s_ready.
module yuv2rgb_stream #(
  parameter int DW   = 8,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_y,
  input  logic [DW-1:0] s_u,
  input  logic [DW-1:0] s_v,
  input  logic          s_mode,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_r,
  output logic [DW-1:0] m_g,
  output logic [DW-1:0] m_b,
  output logic          m_last,
  output logic [31:0]   pix_cnt
);

  localparam int SW = DW + 12;
  localparam logic [DW:0]          C_OFS = (DW+1)'(1 << (DW-1));
  localparam logic signed [SW-1:0] C_RND = SW'(1 << (FRAC-1));
  localparam logic signed [SW-1:0] C_MAX = SW'((1 << DW) - 1);
  localparam logic signed [SW-1:0] K601_RV = SW'(359);
  localparam logic signed [SW-1:0] K601_GU = SW'(88);
  localparam logic signed [SW-1:0] K601_GV = SW'(183);
  localparam logic signed [SW-1:0] K601_BU = SW'(454);
  localparam logic signed [SW-1:0] K709_RV = SW'(403);
  localparam logic signed [SW-1:0] K709_GU = SW'(48);
  localparam logic signed [SW-1:0] K709_GV = SW'(120);
  localparam logic signed [SW-1:0] K709_BU = SW'(475);

  logic                 w_en;
  logic                 r_vld1, r_vld2, r_vld3;
  logic                 r_mode1, r_last1, r_last2, r_last3;
  logic [DW-1:0]        r_y1, r_y2;
  logic signed [DW:0]   r_cb1, r_cr1;
  logic signed [SW-1:0] r_prv, r_pgu, r_pgv, r_pbu;
  logic [DW-1:0]        r_r3, r_g3, r_b3;
  logic [31:0]          r_pix_cnt;

  logic signed [SW-1:0] w_krv, w_kgu, w_kgv, w_kbu, w_cb_x, w_cr_x;
  logic signed [SW-1:0] w_y256, w_r_sum, w_g_sum, w_b_sum;
  logic signed [SW-1:0] w_r_sh, w_g_sh, w_b_sh;

  assign w_en    = !r_vld3 || m_ready;
  assign s_ready = w_en;
  assign m_valid = r_vld3;
  assign m_r     = r_r3;
  assign m_g     = r_g3;
  assign m_b     = r_b3;
  assign m_last  = r_last3;
  assign pix_cnt = r_pix_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1  <= 1'b0;
      r_mode1 <= 1'b0;
      r_last1 <= 1'b0;
      r_y1    <= '0;
      r_cb1   <= '0;
      r_cr1   <= '0;
    end else if (w_en) begin
      r_vld1  <= s_valid;
      r_mode1 <= s_mode;
      r_last1 <= s_last;
      r_y1    <= s_y;
      r_cb1   <= $signed({1'b0, s_u} - C_OFS);
      r_cr1   <= $signed({1'b0, s_v} - C_OFS);
    end
  end

  always_comb begin
    w_krv  = r_mode1 ? K709_RV : K601_RV;
    w_kgu  = r_mode1 ? K709_GU : K601_GU;
    w_kgv  = r_mode1 ? K709_GV : K601_GV;
    w_kbu  = r_mode1 ? K709_BU : K601_BU;
    w_cb_x = SW'(r_cb1);
    w_cr_x = SW'(r_cr1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld2  <= 1'b0;
      r_last2 <= 1'b0;
      r_y2    <= '0;
      r_prv   <= '0;
      r_pgu   <= '0;
      r_pgv   <= '0;
      r_pbu   <= '0;
    end else if (w_en) begin
      r_vld2  <= r_vld1;
      r_last2 <= r_last1;
      r_y2    <= r_y1;
      r_prv   <= w_cr_x * w_krv;
      r_pgu   <= w_cb_x * w_kgu;
      r_pgv   <= w_cr_x * w_kgv;
      r_pbu   <= w_cb_x * w_kbu;
    end
  end

  // Products are exact in SW bits, so the sums below cannot overflow.
  always_comb begin
    w_y256  = $signed(SW'({r_y2, {FRAC{1'b0}}}));
    w_r_sum = w_y256 + r_prv + C_RND;
    w_g_sum = w_y256 - r_pgu - r_pgv + C_RND;
    w_b_sum = w_y256 + r_pbu + C_RND;
    w_r_sh  = w_r_sum >>> FRAC;
    w_g_sh  = w_g_sum >>> FRAC;
    w_b_sh  = w_b_sum >>> FRAC;
  end

  function automatic logic [DW-1:0] f_clip(input logic signed [SW-1:0] x);
    if (x[SW-1])
      return '0;
    else if (x > C_MAX)
      return '1;
    else
      return x[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld3  <= 1'b0;
      r_last3 <= 1'b0;
      r_r3    <= '0;
      r_g3    <= '0;
      r_b3    <= '0;
    end else if (w_en) begin
      r_vld3  <= r_vld2;
      r_last3 <= r_last2;
      r_r3    <= f_clip(w_r_sh);
      r_g3    <= f_clip(w_g_sh);
      r_b3    <= f_clip(w_b_sh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pix_cnt <= '0;
    else if (r_vld3 && m_ready)
      r_pix_cnt <= r_pix_cnt + 32'd1;
  end

endmodule

// File: tb/tb_yuv2rgb_stream.sv
// Bench for yuv2rgb_stream: scoreboard of expected pixels, output-side monitor with
// hold/backpressure/latency checks, directed and random-stall scenarios.
module tb_yuv2rgb_stream;

  localparam int DW = 8;

  typedef struct packed {
    logic [3*DW-1:0] rgb;
    logic            last;
    logic [31:0]     cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_y = '0, s_u = '0, s_v = '0;
  logic          s_mode = 1'b0, s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_r, m_g, m_b;
  logic          m_last;
  logic [31:0]   pix_cnt;

  int            n_chk = 0;
  int            n_err = 0;
  exp_t          q[$];
  logic [31:0]   exp_cnt = 0;
  logic [31:0]   cyc = 0;
  logic          rdy_rand = 1'b0;
  logic          prev_stall = 1'b0;
  logic [3*DW+1:0] prev_out = '0;

  yuv2rgb_stream #(.DW(DW), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_y(s_y), .s_u(s_u), .s_v(s_v), .s_mode(s_mode), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_last(m_last),
    .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] clip(input int x);
    int mx;
    logic [31:0] xv;
    mx = (1 << DW) - 1;
    xv = x;
    if (x < 0) return '0;
    if (x > mx) return DW'(mx);
    return xv[DW-1:0];
  endfunction

  function automatic logic [3*DW-1:0] model(input int y, input int u, input int v, input int md);
    int up, vp, krv, kgu, kgv, kbu, r, g, b;
    up  = u - (1 << (DW-1));
    vp  = v - (1 << (DW-1));
    krv = md ? 403 : 359;
    kgu = md ? 48  : 88;
    kgv = md ? 120 : 183;
    kbu = md ? 475 : 454;
    r = (y*256 + krv*vp + 128) >>> 8;
    g = (y*256 - kgu*up - kgv*vp + 128) >>> 8;
    b = (y*256 + kbu*up + 128) >>> 8;
    return {clip(r), clip(g), clip(b)};
  endfunction

  always begin
    @(posedge clk);
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      cyc++;
      chk("pix_cnt", pix_cnt, exp_cnt);
      if (prev_stall)
        chk("hold", {m_valid, m_r, m_g, m_b, m_last}, prev_out);
      if (m_valid && !m_ready)
        chk("s_ready_stall", s_ready, 0);
      if (m_valid && m_ready) begin
        exp_cnt++;
        if (q.size() == 0)
          chk("spurious_vld", m_valid, 0);
        else begin
          e = q.pop_front();
          chk("rgb", {m_r, m_g, m_b}, e.rgb);
          chk("last", m_last, e.last);
          if (!rdy_rand)
            chk("latency", cyc - e.cyc, 3);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_r, m_g, m_b, m_last};
      if (s_valid && s_ready) begin
        e.rgb  = model(int'(s_y), int'(s_u), int'(s_v), int'(s_mode));
        e.last = s_last;
        e.cyc  = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [DW-1:0] y, input logic [DW-1:0] u, input logic [DW-1:0] v,
                      input logic md, input logic lst);
    logic hs;
    int   guard;
    guard = 0;
    s_valid = 1'b1; s_y = y; s_u = u; s_v = v; s_mode = md; s_last = lst;
    do begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!hs && guard < 200);
    if (!hs) chk("send_timeout", hs, 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    s_valid = 1'b0;
    while (q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    q.delete();
    exp_cnt    = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] ry, ru, rv;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rgb", {m_r, m_g, m_b, m_last}, 0);
    do_reset();
    chk("rst_s_ready", s_ready, 1);

    // Grey
    send(8'h80, 8'h80, 8'h80, 1'b0, 1'b0);
    drain();
    chk("grey_pix_cnt", pix_cnt, 1);

    // Saturation, both directions
    send(8'h22, 8'h15, 8'h12, 1'b0, 1'b0);
    send(8'hFF, 8'h80, 8'hFF, 1'b0, 1'b0);
    drain();
    chk("sat_vec", model(32'h22, 32'h15, 32'h12, 0), 24'h009500);

    // Mode switch on back-to-back pixels
    send(8'h80, 8'h80, 8'hFF, 1'b0, 1'b0);
    send(8'h80, 8'h80, 8'hFF, 1'b1, 1'b0);
    drain();

    // Random backpressure
    do_reset();
    rdy_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ry = DW'($urandom); ru = DW'($urandom); rv = DW'($urandom);
      send(ry, ru, rv, 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
    rdy_rand = 1'b0;
    idle(2);
    chk("bp_pix_cnt", pix_cnt, 10);

    // Line of 8 at full rate, marker on the last
    for (int i = 0; i < 8; i++)
      send(DW'(16*i + 3), DW'(255 - 20*i), DW'(30*i), 1'(i & 1), 1'(i == 7));
    drain();
    chk("line_pix_cnt", pix_cnt, 18);

    // Reset with two pixels in flight
    send(8'h40, 8'h90, 8'h70, 1'b0, 1'b0);
    send(8'hC0, 8'h20, 8'hE0, 1'b1, 1'b1);
    do_reset();
    idle(6);
    chk("post_rst_pix_cnt", pix_cnt, 0);
    send(8'h10, 8'hF0, 8'h08, 1'b1, 1'b1);
    drain();
    chk("post_rst_one", pix_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
